// File: rtl/phase_a_shift_reduce.sv
// phase_a_shift_reduce
// Computes new_a = (a * 2^shift) mod m by repeated doubling with a conditional
// subtract. STEP doublings run per clock, and a run-time count sets how many
// are performed in total. Requests use a valid/ready handshake and so do
// results. An operand with a >= m returns a unchanged with err set.
module phase_a_shift_reduce #(
    parameter int WIDTH = 3072,
    parameter int STEP  = 1,
    parameter int KW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic [KW-1:0]    shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] new_a,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [KW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] new_a_reg, new_a_next;
    logic             out_valid_reg, out_valid_next;
    logic             err_reg, err_next;

    // The residue r stays below m, so 2r fits in WIDTH+1 bits.
    // Compare and subtract therefore run at WIDTH+1 bits.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   step_result;
    logic [KW-1:0]    n_steps;

    assign m_ext   = {1'b0, m_reg};
    assign n_steps = (cnt_reg > KW'(STEP)) ? KW'(STEP) : cnt_reg;

    // Unrolled chain of doubling steps. A stage whose index is at or beyond
    // the remaining count passes its input through unchanged. This lets the
    // final cycle of a run perform fewer than STEP doublings.
    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
        logic [WIDTH:0] prev;
        logic [WIDTH:0] dbl;
        logic [WIDTH:0] res;

        if (gi == 0) begin : g_first
            assign prev = r_reg;
        end else begin : g_chain
            assign prev = g_step[gi-1].res;
        end

        assign dbl = prev << 1;
        assign res = (cnt_reg > KW'(gi)) ? ((dbl >= m_ext) ? (dbl - m_ext) : dbl)
                                         : prev;
    end

    assign step_result = g_step[STEP-1].res;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            r_reg         <= '0;
            m_reg         <= '0;
            cnt_reg       <= '0;
            new_a_reg     <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            r_reg         <= r_next;
            m_reg         <= m_next;
            cnt_reg       <= cnt_next;
            new_a_reg     <= new_a_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, hold the result in DONE.
    always_comb begin
        state_next     = state_reg;
        r_next         = r_reg;
        m_next         = m_reg;
        cnt_next       = cnt_reg;
        new_a_next     = new_a_reg;
        out_valid_next = out_valid_reg;
        err_next       = err_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    r_next   = {1'b0, a};
                    m_next   = m;
                    cnt_next = shift;
                    if (a >= m) begin
                        // Out-of-range operand, including m == 0.
                        state_next     = DONE;
                        new_a_next     = a;
                        err_next       = 1'b1;
                        out_valid_next = 1'b1;
                    end else if (shift == '0) begin
                        state_next     = DONE;
                        new_a_next     = a;
                        err_next       = 1'b0;
                        out_valid_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                r_next   = step_result;
                cnt_next = cnt_reg - n_steps;
                if (cnt_reg == n_steps) begin
                    state_next     = DONE;
                    new_a_next     = step_result[WIDTH-1:0];
                    err_next       = 1'b0;
                    out_valid_next = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign new_a     = new_a_reg;
    assign err       = err_reg;

endmodule
